// File: rtl/alu_pkg.sv
// alu_pkg: alucode map, FSM state encoding and default width shared by
// the ALU control decoder and alu_exec_unit so both ends agree.
package alu_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    function automatic logic is_shift(input logic [3:0] code);
        return code == ALU_SLL || code == ALU_SRL || code == ALU_SRA;
    endfunction
endpackage

// File: rtl/alu_exec_unit_iter.sv
// alu_iter_core: iterative datapath, one shift bit (or one shift-add step) per cycle.
// Ports: start_i loads a_i/b_i/op_i with amt_i iterations; done_o is high in the
// final iteration cycle and res_o then carries that iteration's result.
// Macro ALU_MUL_EN adds the multiplier operand and shift-add accumulator.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [XLEN-1:0]    a_i,
`ifdef ALU_MUL_EN
    input  logic [XLEN-1:0]    b_i,
`endif
    input  logic [SHAMT_W:0]   amt_i,
    output logic               done_o,
    output logic [XLEN-1:0]    res_o
);
    logic [XLEN-1:0]  val_q, val_nxt;
    logic [SHAMT_W:0] cnt_q;
    logic [3:0]       op_q;
    logic             busy_q;
    // Multiplicand shares val_q with the shifter: both shift left by one.
    assign val_nxt = op_q == ALU_SRL ? val_q >> 1 :
                     op_q == ALU_SRA ? {val_q[XLEN-1], val_q[XLEN-1:1]} : val_q << 1;
    assign done_o  = busy_q && cnt_q == 1;
`ifdef ALU_MUL_EN
    logic [XLEN-1:0] acc_q, mplr_q, acc_nxt;
    assign acc_nxt = mplr_q[0] ? acc_q + val_q : acc_q;
    assign res_o   = op_q == ALU_MUL ? acc_nxt : val_nxt;
`else
    assign res_o   = val_nxt;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            busy_q <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q  <= '0;
            mplr_q <= '0;
`endif
        end else if (start_i) begin
            val_q  <= a_i;
            cnt_q  <= amt_i;
            op_q   <= op_i;
            busy_q <= 1'b1;
`ifdef ALU_MUL_EN
            acc_q  <= '0;
            mplr_q <= b_i;
`endif
        end else if (busy_q) begin
            val_q  <= val_nxt;
            cnt_q  <= cnt_q - 1'b1;
            busy_q <= cnt_q != 1;
`ifdef ALU_MUL_EN
            acc_q  <= acc_nxt;
            mplr_q <= mplr_q >> 1;
`endif
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU executing the 4-bit alucode with valid/ready on both sides.
// Ports: in_valid/in_ready/alucode/op_a/op_b request side; out_valid/out_ready/result/
// zero/illegal result side (illegal qualified by out_valid). clk, sync active-high rst.
// Macro ALU_MUL_EN enables the shift-add multiply for alucode 1010; otherwise it is illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucode,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    logic [1:0]         state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d, simple_res, iter_res;
    logic               zero_q, zero_d, illegal_q, illegal_d;
    logic               is_mul, legal, start, iter_done;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W:0]   amt;
`ifdef ALU_MUL_EN
    assign is_mul = alucode == ALU_MUL;
`else
    assign is_mul = 1'b0;
`endif
    assign legal     = alucode <= ALU_SRA || is_mul;
    assign shamt     = op_b[SHAMT_W-1:0];
    assign amt       = is_mul ? (SHAMT_W+1)'(XLEN) : {1'b0, shamt};
    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    // Zero-amount shifts finish here with op_a; illegal codes fall through to 0.
    assign start = in_ready && in_valid && (is_mul || (is_shift(alucode) && shamt != '0));
    assign simple_res = alucode == ALU_ADD  ? op_a + op_b :
                        alucode == ALU_OR   ? op_a | op_b :
                        alucode == ALU_AND  ? op_a & op_b :
                        alucode == ALU_XOR  ? op_a ^ op_b :
                        alucode == ALU_SUB  ? op_a - op_b :
                        alucode == ALU_SLT  ? {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)} :
                        alucode == ALU_SLTU ? {{(XLEN-1){1'b0}}, op_a < op_b} :
                        is_shift(alucode)   ? op_a : '0;
    alu_iter_core #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .op_i   (alucode),
        .a_i    (op_a),
`ifdef ALU_MUL_EN
        .b_i    (op_b),
`endif
        .amt_i  (amt),
        .done_o (iter_done),
        .res_o  (iter_res)
    );
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (in_ready && in_valid) begin
            if (start) begin
                state_d = is_mul ? S_MUL : S_SHIFT;
            end else begin
                state_d   = S_DONE;
                result_d  = simple_res;
                zero_d    = simple_res == '0;
                illegal_d = !legal;
            end
        end else if ((state_q == S_SHIFT || state_q == S_MUL) && iter_done) begin
            state_d   = S_DONE;
            result_d  = iter_res;
            zero_d    = iter_res == '0;
            illegal_d = 1'b0;
        end else if (out_valid && out_ready) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scoreboard bench for alu_exec_unit.
module tb_alu_exec_unit;
    import alu_pkg::*;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [3:0]  alucode;
    logic [31:0] op_a, op_b;
    logic        in_ready, out_valid, zero, illegal;
    logic [31:0] result;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    exp_t        got;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alucode  (alucode),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a | b;
            4'd2:    return a & b;
            4'd3:    return a ^ b;
            4'd4:    return a - b;
            4'd5:    return {31'b0, $signed(a) < $signed(b)};
            4'd6:    return {31'b0, a < b};
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return $signed(a) >>> b[4:0];
            4'd10:   return MUL_EN ? a * b : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = model(c, a, b);
        e.z   = e.res == 32'd0;
        e.ill = c > 4'd10 || (c == 4'd10 && !MUL_EN);
        e.lat = (c >= 4'd7 && c <= 4'd9 && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 :
                (c == 4'd10 && MUL_EN) ? 33 : 1;
        @(negedge clk);
        chk("accept_ready", 32'(in_ready), 32'd1);
        alucode  = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, output exp_t e);
        int lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_zero"}, 32'(zero), 32'(e.z));
        chk({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
        chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alucode = 4'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);  recv("add_wrap", got);
        chk("add_const", got.res, 32'h8000_0000);
        send(ALU_SUB, 32'd5, 32'd5);                  recv("sub_zero", got);
        send(ALU_SLT, 32'hFFFF_FFFF, 32'd1);          recv("slt", got);
        chk("slt_const", got.res, 32'd1);
        send(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);         recv("sltu", got);
        send(ALU_OR, 32'hF0F0_0000, 32'h0000_0F0F);   recv("or", got);
        send(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);  recv("and", got);
        send(ALU_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF);  recv("xor", got);
        send(ALU_SUB, 32'd0, 32'd1);                  recv("sub_wrap", got);
        send(ALU_SRA, 32'h8000_0000, 32'd4);          recv("sra4", got);
        chk("sra_const", got.res, 32'hF800_0000);
        send(ALU_SRL, 32'h8000_0000, 32'd31);         recv("srl31", got);
        send(ALU_SLL, 32'h0000_0003, 32'h0000_0023);  recv("sll_mask", got);
        send(ALU_SLL, 32'hDEAD_BEEF, 32'd0);          recv("sll0", got);
        send(ALU_SRA, 32'h4000_0000, 32'd1);          recv("sra_pos", got);
        send(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001);  recv("mul", got);
        send(ALU_MUL, 32'h1234_5678, 32'd0);          recv("mul_zero", got);
        send(4'b1111, 32'h1234_5678, 32'd9);          recv("illegal_f", got);
        send(4'b1011, 32'd1, 32'd1);                  recv("illegal_b", got);

        out_ready = 1'b0;
        send(ALU_ADD, 32'h0000_1000, 32'h0000_0234);
        recv("bp", got);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            alucode = ALU_SUB; op_a = 32'd7; op_b = 32'd7; in_valid = 1'b1;
            chk("bp_stable_result", result, 32'h0000_1234);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_ignored_req", 32'(out_valid), 32'd0);
        chk("bp_result_kept", result, 32'h0000_1234);

        send(ALU_SLL, 32'd1, 32'd20);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_late_valid", 32'(out_valid), 32'd0);
        send(ALU_ADD, 32'd40, 32'd2);                 recv("post_abort_add", got);
        chk("post_abort_const", got.res, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
